// File: rtl/memory_writeback_stage_pkg.sv
// Shared definitions for the memory/writeback stage: FSM state encoding,
// default datapath widths and control-bit polarities.
package memory_writeback_stage_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 4;

    // loadStoreIN / byteOrWordIN / prePostAddOffsetIN polarities
    localparam logic LS_LOAD   = 1'b1;
    localparam logic LS_STORE  = 1'b0;
    localparam logic BW_BYTE   = 1'b1;
    localparam logic BW_WORD   = 1'b0;
    localparam logic IDX_PRE   = 1'b1;
    localparam logic IDX_POST  = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM     = 2'd1,
        BASE_WB = 2'd2
    } state_t;

endpackage

// File: rtl/memory_writeback_stage_if.sv
// Data-memory request bus between the memory/writeback stage (master) and
// the data memory (slave).
//   memReqOUT/memWriteOUT/memByteOUT/memAddrOUT/memWdataOUT : request, master -> slave
//   memRdataIN/memReadyIN                                    : response, slave -> master
interface memory_writeback_stage_if
    import memory_writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  memReqOUT;
    logic                  memWriteOUT;
    logic                  memByteOUT;
    logic [DATA_WIDTH-1:0] memAddrOUT;
    logic [DATA_WIDTH-1:0] memWdataOUT;
    logic [DATA_WIDTH-1:0] memRdataIN;
    logic                  memReadyIN;

    modport master (
        output memReqOUT, memWriteOUT, memByteOUT, memAddrOUT, memWdataOUT,
        input  memRdataIN, memReadyIN
    );

    modport slave (
        input  memReqOUT, memWriteOUT, memByteOUT, memAddrOUT, memWdataOUT,
        output memRdataIN, memReadyIN
    );
endinterface

// File: rtl/memory_writeback_stage_load_store_align.sv
// Byte-lane handling for the data-memory path (purely combinational).
//   store_byte, store_data -> store_lanes : byte stores replicate [7:0] on every lane
//   load_byte, load_lane, load_data -> load_value : byte loads pick one lane, zero-extended
module memory_writeback_stage_load_store_align
    import memory_writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  store_byte,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] store_lanes,
    input  logic                  load_byte,
    input  logic [1:0]            load_lane,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] load_value
);
    always_comb begin
        store_lanes = store_data;
        if (store_byte == BW_BYTE) begin
            store_lanes = {(DATA_WIDTH/8){store_data[7:0]}};
        end
    end

    always_comb begin
        load_value = load_data;
        if (load_byte == BW_BYTE) begin
            load_value      = '0;
            load_value[7:0] = load_data[{load_lane, 3'b000} +: 8];
        end
    end
endmodule

// File: rtl/memory_writeback_stage.sv
// Memory/writeback pipeline stage.
//   clk, reset (async, active-low)
//   execute-stage inputs : validIN, regWriteIN, memOpIN, loadStoreIN, byteOrWordIN,
//                          prePostAddOffsetIN, writeBackIN, aluResultIN, baseIN,
//                          storeDataIN, rdIN, rnIN
//   stallOUT             : upstream hold while a memory op / base writeback runs
//   mem                  : data-memory request bus (master side)
//   rfWriteEnOUT/rfWriteAddrOUT/rfWriteDataOUT : register file write port
module memory_writeback_stage
    import memory_writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      validIN,
    input  logic                      regWriteIN,
    input  logic                      memOpIN,
    input  logic                      loadStoreIN,
    input  logic                      byteOrWordIN,
    input  logic                      prePostAddOffsetIN,
    input  logic                      writeBackIN,
    input  logic [DATA_WIDTH-1:0]     aluResultIN,
    input  logic [DATA_WIDTH-1:0]     baseIN,
    input  logic [DATA_WIDTH-1:0]     storeDataIN,
    input  logic [REG_ADDR_WIDTH-1:0] rdIN,
    input  logic [REG_ADDR_WIDTH-1:0] rnIN,
    output logic                      stallOUT,
    memory_writeback_stage_if.master  mem,
    output logic                      rfWriteEnOUT,
    output logic [REG_ADDR_WIDTH-1:0] rfWriteAddrOUT,
    output logic [DATA_WIDTH-1:0]     rfWriteDataOUT
);
    state_t state, state_next;

    logic [REG_ADDR_WIDTH-1:0] rd_q, rn_q;
    logic [DATA_WIDTH-1:0]     alu_q;
    logic                      load_q, byte_q, base_upd_q;
    logic [DATA_WIDTH-1:0]     store_lanes, load_value;
    logic                      skip_base_wb;

    memory_writeback_stage_load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .store_byte  (byteOrWordIN),
        .store_data  (storeDataIN),
        .store_lanes (store_lanes),
        .load_byte   (byte_q),
        .load_lane   (mem.memAddrOUT[1:0]),
        .load_data   (mem.memRdataIN),
        .load_value  (load_value)
    );

    // A load into its own base register keeps the loaded value.
    assign skip_base_wb = (load_q == LS_LOAD) && (rn_q == rd_q);
    assign stallOUT     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (validIN && memOpIN) state_next = MEM;
            MEM:     if (mem.memReadyIN)
                         state_next = (base_upd_q && !skip_base_wb) ? BASE_WB : IDLE;
            BASE_WB: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q            <= '0;
            rn_q            <= '0;
            alu_q           <= '0;
            load_q          <= 1'b0;
            byte_q          <= 1'b0;
            base_upd_q      <= 1'b0;
            mem.memReqOUT   <= 1'b0;
            mem.memWriteOUT <= 1'b0;
            mem.memByteOUT  <= 1'b0;
            mem.memAddrOUT  <= '0;
            mem.memWdataOUT <= '0;
            rfWriteEnOUT    <= 1'b0;
            rfWriteAddrOUT  <= '0;
            rfWriteDataOUT  <= '0;
        end else begin
            rfWriteEnOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (validIN && memOpIN) begin
                        rd_q            <= rdIN;
                        rn_q            <= rnIN;
                        alu_q           <= aluResultIN;
                        load_q          <= loadStoreIN;
                        byte_q          <= byteOrWordIN;
                        base_upd_q      <= writeBackIN || (prePostAddOffsetIN == IDX_POST);
                        mem.memReqOUT   <= 1'b1;
                        mem.memWriteOUT <= (loadStoreIN == LS_STORE);
                        mem.memByteOUT  <= byteOrWordIN;
                        mem.memAddrOUT  <= (prePostAddOffsetIN == IDX_PRE) ? aluResultIN : baseIN;
                        mem.memWdataOUT <= store_lanes;
                    end else if (validIN && regWriteIN) begin
                        rfWriteEnOUT   <= 1'b1;
                        rfWriteAddrOUT <= rdIN;
                        rfWriteDataOUT <= aluResultIN;
                    end
                end
                MEM: begin
                    if (mem.memReadyIN) begin
                        mem.memReqOUT <= 1'b0;
                        if (load_q == LS_LOAD) begin
                            rfWriteEnOUT   <= 1'b1;
                            rfWriteAddrOUT <= rd_q;
                            rfWriteDataOUT <= load_value;
                        end
                    end
                end
                BASE_WB: begin
                    rfWriteEnOUT   <= 1'b1;
                    rfWriteAddrOUT <= rn_q;
                    rfWriteDataOUT <= alu_q;
                end
                default: ;
            endcase
        end
    end
endmodule
